fetch_predict_stage: RTL and testbench
======================================

// Module: fetch_predict_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC register, drives the instruction-memory address, and
//  predicts the next PC with a direct-mapped BHT/BTB of 2-bit counters. Feeds the IF/ID
//  register with pc_4, pc_guessed and bht_state. Later stages return resolved branches through
//  the update port and mispredict redirects through redirect_*.
//  All PCs are IM word addresses, so pc_4 = pc + 1 (wraps modulo 2^`IM_ADDR_BIT).
// PARAMETERS
//  BHT_IDX_BIT  6  table index width; 2^BHT_IDX_BIT entries; index = pc[BHT_IDX_BIT-1:0]
//  RESET_PC     0  PC value loaded on reset (width `IM_ADDR_BIT)
// PORTS
//  clk          in   1                 clock, posedge
//  rst_n        in   1                 asynchronous active-low reset
//  en           in   1                 1 = advance PC; 0 = hold (stall)
//  redirect_en  in   1                 mispredict or jump correction from a later stage
//  redirect_pc  in   `IM_ADDR_BIT      corrected next PC
//  upd_en       in   1                 resolved conditional branch, write table
//  upd_pc       in   `IM_ADDR_BIT      PC of the resolved branch
//  upd_taken    in   1                 actual direction
//  upd_target   in   `IM_ADDR_BIT      actual taken target
//  upd_state    in   2                 bht_state captured at fetch, carried down the pipe
//  im_addr      out  `IM_ADDR_BIT      = pc (combinational)
//  pc_4         out  `IM_ADDR_BIT      = pc + 1
//  pc_guessed   out  `IM_ADDR_BIT      predicted next PC
//  bht_state    out  2                 counter read for pc (2'b01 on miss)
// BEHAVIOUR
//  - Reset (async): pc <= RESET_PC; all entry valid bits <= 0; all counters <= 2'b01.
//    After reset, im_addr = RESET_PC, pc_4 = RESET_PC+1, pc_guessed = RESET_PC+1,
//    bht_state = 2'b01. Reset asserted mid-operation discards pending updates and redirects.
//  - Entry: {valid, tag = pc[`IM_ADDR_BIT-1:BHT_IDX_BIT], target, ctr[1:0]}.
//    Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - Lookup (combinational on pc): hit = valid && tag match.
//    pc_guessed = (hit && ctr[1]) ? target : pc+1. bht_state = hit ? ctr : 2'b01.
//  - Next-PC priority on each posedge: redirect_en -> redirect_pc (overrides en=0);
//    else !en -> hold pc; else pc_guessed. Latency: redirect visible on im_addr 1 cycle later.
//  - Update, one cycle, on posedge when upd_en:
//    new = upd_taken ? sat_inc(upd_state) : sat_dec(upd_state); saturates at 11 and 00.
//    Tag match at upd_pc index: ctr <= new; target <= upd_target only if upd_taken.
//    Tag miss and upd_taken: allocate (valid=1, tag, target, ctr <= 2'b10).
//    Tag miss and !upd_taken: no write.
//  - Update ignores en and redirect_en; it writes even while stalled.
//  - Same-cycle lookup and update on the same index: lookup returns the old entry (read-before-write).
//  - pc + 1 and wrap: pc = all-ones gives pc_4 = 0.
// CONFIGURATION
//  FETCH_BHT_EN defined: predictor as above.
//  Not defined: no table storage. pc_guessed = pc+1; bht_state = 2'b00; upd_* ignored.
//  Redirect, stall and reset behaviour are unchanged.
// TESTING
//  1. Reset with en=1 and no other inputs: im_addr = 0,1,2,3 on successive cycles;
//     bht_state = 01 throughout.
//  2. upd_en, upd_pc=0x10, taken, target=0x40, state=01; later fetch 0x10:
//     pc_guessed = 0x40, bht_state = 10; next im_addr = 0x40.
//  3. Entry at 11 updated taken -> stays 11. Entry at 00 updated not-taken -> stays 00.
//     Entry at 10 updated not-taken -> 01, then fetch predicts pc+1.
//  4. en=0 and redirect_en=1 with redirect_pc=0x80 in the same cycle: next im_addr = 0x80.
//     en=0 alone: im_addr holds for 3 cycles.
//  5. pc 0x05 and pc 0x45 alias at BHT_IDX_BIT=6: allocate 0x05; fetch 0x45 -> miss, pc_guessed = 0x46.
//     Not-taken update at 0x45 leaves the 0x05 entry intact.
//  6. Build without FETCH_BHT_EN and repeat test 2: pc_guessed = 0x11, bht_state = 00.

Source files
------------

// File: rtl/fetch_predict_stage.sv
// ---------------------------------------------------------------------------
// fetch_predict_stage
//
// Instruction-fetch stage. Owns the PC, drives the instruction-memory word
// address and predicts the next PC. The prediction comes from a direct-mapped
// BHT/BTB of 2-bit saturating counters when FETCH_BHT_EN is defined.
// Without FETCH_BHT_EN the stage has no table: it predicts pc+1 and reports
// bht_state = 2'b00. Redirect, stall and reset behave the same in both builds.
//
// Build option: `define FETCH_BHT_EN to include the branch predictor.
// Address width comes from `IM_ADDR_BIT. It defaults to 12 when the includer
// has not set it.
//
// Ports
//   clk          posedge clock
//   rst_n        asynchronous active-low reset
//   en           1 = advance the PC, 0 = hold (stall)
//   redirect_en  correction from a later stage; wins over en=0
//   redirect_pc  corrected next PC
//   upd_en       resolved conditional branch; writes the table
//   upd_pc       PC of the resolved branch
//   upd_taken    actual direction
//   upd_target   actual taken target
//   upd_state    counter value captured at fetch and carried down the pipe
//   im_addr      current PC (combinational)
//   pc_4         pc + 1 (word address, wraps)
//   pc_guessed   predicted next PC
//   bht_state    counter read for pc (2'b01 on a miss, 2'b00 without a table)
// ---------------------------------------------------------------------------
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 12
`endif

module fetch_predict_stage #(
  parameter int                     BHT_IDX_BIT = 6,
  parameter logic [`IM_ADDR_BIT-1:0] RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    redirect_en,
  input  logic [`IM_ADDR_BIT-1:0] redirect_pc,
  input  logic                    upd_en,
  input  logic [`IM_ADDR_BIT-1:0] upd_pc,
  input  logic                    upd_taken,
  input  logic [`IM_ADDR_BIT-1:0] upd_target,
  input  logic [1:0]              upd_state,
  output logic [`IM_ADDR_BIT-1:0] im_addr,
  output logic [`IM_ADDR_BIT-1:0] pc_4,
  output logic [`IM_ADDR_BIT-1:0] pc_guessed,
  output logic [1:0]              bht_state
);

  localparam int AW = `IM_ADDR_BIT;

  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;

  assign im_addr = pc_reg;
  assign pc_4    = pc_reg + AW'(1);

`ifdef FETCH_BHT_EN
  localparam int TAG_W   = AW - BHT_IDX_BIT;
  localparam int ENTRIES = 1 << BHT_IDX_BIT;

  // The valid bits and counters need reset. The tag and target fields do not,
  // so they sit in a plain array.
  logic                valid_reg  [ENTRIES];
  logic [1:0]          ctr_reg    [ENTRIES];
  logic [TAG_W-1:0]    tag_reg    [ENTRIES];
  logic [AW-1:0]       target_reg [ENTRIES];

  logic [BHT_IDX_BIT-1:0] rd_idx;
  logic [TAG_W-1:0]       rd_tag;
  logic                   rd_hit;
  logic [BHT_IDX_BIT-1:0] wr_idx;
  logic [TAG_W-1:0]       wr_tag;
  logic                   wr_hit;
  logic [1:0]             ctr_next;

  assign rd_idx = pc_reg[BHT_IDX_BIT-1:0];
  assign rd_tag = pc_reg[AW-1:BHT_IDX_BIT];
  assign rd_hit = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);

  // The lookup reads the registered table. An update in the same cycle only
  // becomes visible after the edge, so a same-index update reads the old entry.
  assign pc_guessed = (rd_hit && ctr_reg[rd_idx][1]) ? target_reg[rd_idx] : pc_4;
  assign bht_state  = rd_hit ? ctr_reg[rd_idx] : 2'b01;

  assign wr_idx = upd_pc[BHT_IDX_BIT-1:0];
  assign wr_tag = upd_pc[AW-1:BHT_IDX_BIT];
  assign wr_hit = valid_reg[wr_idx] && (tag_reg[wr_idx] == wr_tag);

  // The new counter value starts from the value seen at fetch time, not from
  // the current table content.
  always_comb begin
    ctr_next = upd_state;
    if (upd_taken) begin
      if (upd_state != 2'b11) ctr_next = upd_state + 2'd1;
    end else begin
      if (upd_state != 2'b00) ctr_next = upd_state - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        ctr_reg[wr_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_reg[wr_idx] <= 1'b1;
        ctr_reg[wr_idx]   <= 2'b10;
      end
    end
  end

  // Updates ignore en and redirect_en, so they still write during a stall.
  always_ff @(posedge clk) begin
    if (rst_n && upd_en && upd_taken) begin
      tag_reg[wr_idx]    <= wr_tag;
      target_reg[wr_idx] <= upd_target;
    end
  end
`else
  assign pc_guessed = pc_4;
  assign bht_state  = 2'b00;

  logic upd_unused;
  assign upd_unused = ^{upd_en, upd_pc, upd_taken, upd_target, upd_state};
`endif

  // A redirect overrides a stall.
  always_comb begin
    pc_next = pc_reg;
    if (redirect_en)
      pc_next = redirect_pc;
    else if (en)
      pc_next = pc_guessed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_predict_stage
//
// Directed bench for fetch_predict_stage. Expected outputs are pushed to a
// scoreboard queue and popped against the DUT at the falling edge. The
// expectations follow FETCH_BHT_EN: without it, the bench expects pc+1 and
// state 00.
// ---------------------------------------------------------------------------
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 12
`endif

module tb_fetch_predict_stage;

  localparam int AW = `IM_ADDR_BIT;
`ifdef FETCH_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          redirect_en;
  logic [AW-1:0] redirect_pc;
  logic          upd_en;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic [1:0]    upd_state;
  logic [AW-1:0] im_addr;
  logic [AW-1:0] pc_4;
  logic [AW-1:0] pc_guessed;
  logic [1:0]    bht_state;

  fetch_predict_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_state   (upd_state),
    .im_addr     (im_addr),
    .pc_4        (pc_4),
    .pc_guessed  (pc_guessed),
    .bht_state   (bht_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [AW-1:0] im;
    logic [AW-1:0] pc4;
    logic [AW-1:0] guess;
    logic [1:0]    st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Without the predictor, the table-derived fields fall back to pc+1 / 00.
  task automatic expect_out(input string tag, input logic [AW-1:0] im,
                            input logic [AW-1:0] g_bht, input logic [1:0] st_bht);
    exp_t e;
    e.tag   = tag;
    e.im    = im;
    e.pc4   = im + AW'(1);
    e.guess = BHT ? g_bht : im + AW'(1);
    e.st    = BHT ? st_bht : 2'b00;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty got no expectation required one");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (im_addr === e.im) else begin
      errors++;
      $error("FAIL %s im_addr got %h exp %h", e.tag, im_addr, e.im);
    end
    checks++;
    assert (pc_4 === e.pc4) else begin
      errors++;
      $error("FAIL %s pc_4 got %h exp %h", e.tag, pc_4, e.pc4);
    end
    checks++;
    assert (pc_guessed === e.guess) else begin
      errors++;
      $error("FAIL %s pc_guessed got %h exp %h", e.tag, pc_guessed, e.guess);
    end
    checks++;
    assert (bht_state === e.st) else begin
      errors++;
      $error("FAIL %s bht_state got %b exp %b", e.tag, bht_state, e.st);
    end
    $display("txn %-12s im=%h pc4=%h guess=%h st=%b", e.tag, im_addr, pc_4, pc_guessed, bht_state);
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] im,
                     input logic [AW-1:0] g_bht, input logic [1:0] st_bht);
    expect_out(tag, im, g_bht, st_bht);
    check_out();
  endtask

  task automatic drive(input logic e, input logic r, input logic [AW-1:0] rpc,
                       input logic u, input logic [AW-1:0] upc, input logic tk,
                       input logic [AW-1:0] tgt, input logic [1:0] st);
    en          = e;
    redirect_en = r;
    redirect_pc = rpc;
    upd_en      = u;
    upd_pc      = upc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_state   = st;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("reset", 12'h000, 12'h001, 2'b01);

    // Free-running fetch from reset.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expect_out("seq", AW'(i), AW'(i + 1), 2'b01);
    for (int i = 0; i < 4; i++) begin
      check_out();
      if (i < 3) cycle();
    end

    // Allocate 0x10 -> 0x40, then redirect to it and follow the prediction.
    drive(1'b1, 1'b0, '0, 1'b1, 12'h010, 1'b1, 12'h040, 2'b01);
    cycle();
    chk("miss4", 12'h004, 12'h005, 2'b01);
    drive(1'b1, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("hit10", 12'h010, 12'h040, 2'b10);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("follow", BHT ? 12'h040 : 12'h011, BHT ? 12'h041 : 12'h012, 2'b01);

    // Redirect wins over a stall.
    drive(1'b0, 1'b1, 12'h080, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("redir_stl", 12'h080, 12'h081, 2'b01);

    // Hold at 0x10 while the table is updated.
    drive(1'b0, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("hold10", 12'h010, 12'h040, 2'b10);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h010, 1'b1, 12'h040, 2'b11);
    cycle();
    chk("sat_hi", 12'h010, 12'h040, 2'b11);
    cycle();
    chk("sat_hi2", 12'h010, 12'h040, 2'b11);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h010, 1'b0, 12'h000, 2'b00);
    cycle();
    chk("sat_lo", 12'h010, 12'h011, 2'b00);
    cycle();
    chk("sat_lo2", 12'h010, 12'h011, 2'b00);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h010, 1'b1, 12'h055, 2'b01);
    cycle();
    chk("new_tgt", 12'h010, 12'h055, 2'b10);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h010, 1'b0, 12'h099, 2'b10);
    cycle();
    chk("weak_nt", 12'h010, 12'h011, 2'b01);

    // Plain stall: PC holds for three cycles.
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
    for (int i = 0; i < 3; i++) expect_out("stall", 12'h010, 12'h011, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_out();
    end

    // 0x05 and 0x45 share index 5.
    drive(1'b1, 1'b1, 12'h045, 1'b1, 12'h005, 1'b1, 12'h020, 2'b01);
    cycle();
    chk("alias_miss", 12'h045, 12'h046, 2'b01);
    drive(1'b0, 1'b1, 12'h005, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("alias_hit", 12'h005, 12'h020, 2'b10);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h045, 1'b0, 12'h000, 2'b10);
    cycle();
    chk("alias_keep", 12'h005, 12'h020, 2'b10);

    // Wrap at the top of the address space.
    drive(1'b1, 1'b1, 12'hFFF, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("wrap", 12'hFFF, 12'h000, 2'b01);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("wrap_next", 12'h000, 12'h001, 2'b01);

    // Reset in the middle of a redirect and an update discards both.
    drive(1'b1, 1'b1, 12'h080, 1'b1, 12'h030, 1'b1, 12'h070, 2'b01);
    rst_n = 1'b0;
    cycle();
    chk("rst_mid", 12'h000, 12'h001, 2'b01);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("rst_clr", 12'h010, 12'h011, 2'b01);
    drive(1'b0, 1'b1, 12'h030, 1'b0, '0, 1'b0, '0, 2'b00);
    cycle();
    chk("rst_upd", 12'h030, 12'h031, 2'b01);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_left got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
